// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin arbiter sharing one PSRAM controller among NUM_REQ requesters.
// Optional WAIT-state timeout is compiled in when PSRAM_ARB_TIMEOUT_EN is defined.
module psram_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_rd_wr,
    input  logic [NUM_REQ*24-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    input  logic [NUM_REQ*3-1:0]   req_size,
    output logic [NUM_REQ-1:0]     req_gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [23:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [2:0]             mem_size,
    output logic                   mem_rd_wr,
    output logic                   mem_start,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int unsigned NUM_REQ_U = NUM_REQ;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("psram_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [IDX_W-1:0]     owner_reg;
    logic [23:0]          addr_reg;
    logic [31:0]          wdata_reg;
    logic [2:0]           size_reg;
    logic                 rd_wr_reg;
    logic [NUM_REQ-1:0]   req_gnt_reg;
    logic [NUM_REQ-1:0]   rsp_valid_reg;
    logic [31:0]          rsp_rdata_reg;
    logic                 busy_reg;
    logic                 mem_start_reg;

    logic [23:0]          addr_arr  [NUM_REQ];
    logic [31:0]          wdata_arr [NUM_REQ];
    logic [2:0]           size_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*24 +: 24];
        assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
        assign size_arr[gi]  = req_size[gi*3 +: 3];
    end

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                   input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= NUM_REQ_U) begin
            s = s - NUM_REQ_U;
        end
        return s[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand;

    // Scan from the farthest offset down so the nearest set bit at/after rr_ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr_reg, i);
            if (req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    logic [IDX_W-1:0] owner_next_ptr;
    assign owner_next_ptr = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             rsp_err_reg;
    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            size_reg      <= '0;
            rd_wr_reg     <= 1'b0;
            req_gnt_reg   <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            busy_reg      <= 1'b0;
            mem_start_reg <= 1'b0;
`ifdef PSRAM_ARB_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            req_gnt_reg   <= '0;
            rsp_valid_reg <= '0;
            mem_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (sel_found) begin
                        owner_reg     <= sel_idx;
                        addr_reg      <= addr_arr[sel_idx];
                        wdata_reg     <= wdata_arr[sel_idx];
                        size_reg      <= size_arr[sel_idx];
                        rd_wr_reg     <= req_rd_wr[sel_idx];
                        req_gnt_reg   <= onehot(sel_idx);
                        mem_start_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_reg <= S_WAIT;
`ifdef PSRAM_ARB_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                S_WAIT: begin
                    if (mem_done) begin
                        rsp_rdata_reg <= rd_wr_reg ? mem_rdata : 32'h0;
                        rsp_valid_reg <= onehot(owner_reg);
                        state_reg     <= S_RESP;
`ifdef PSRAM_ARB_TIMEOUT_EN
                        rsp_err_reg   <= 1'b0;
                    end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        rsp_rdata_reg <= 32'h0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= onehot(owner_reg);
                        state_reg     <= S_RESP;
                    end else begin
                        wait_cnt_reg  <= wait_cnt_reg + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    rr_ptr_reg <= owner_next_ptr;
                    busy_reg   <= 1'b0;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign req_gnt   = req_gnt_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign busy      = busy_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_size  = size_reg;
    assign mem_rd_wr = rd_wr_reg;
    assign mem_start = mem_start_reg;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model; timeout scenario when PSRAM_ARB_TIMEOUT_EN is set.
module tb_psram_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_rd_wr = '0;
    logic [N*24-1:0] req_addr = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N*3-1:0]  req_size = '0;
    logic [N-1:0]    req_gnt;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic [23:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [2:0]      mem_size;
    logic            mem_rd_wr;
    logic            mem_start;
    logic [31:0]     mem_rdata = '0;
    logic            mem_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int ptr_m = 0;
    logic [N-1:0] gnt_log [$];

    psram_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rd_wr (req_rd_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_gnt   (req_gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_rd_wr (mem_rd_wr),
        .mem_start (mem_start),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requesting index at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic set_fields(input int k, input logic [23:0] a, input logic [31:0] d,
                              input logic [2:0] s, input logic rd);
        req_addr[k*24 +: 24] = a;
        req_wdata[k*32 +: 32] = d;
        req_size[k*3 +: 3] = s;
        req_rd_wr[k] = rd;
    endtask

    // Called at a negedge with the DUT idle and at least one request raised.
    task automatic run_txn(input int delay, input logic [31:0] rdata, input bit drop, input bit stray);
        int own;
        logic [N-1:0] oh;
        logic [23:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [2:0] s;
        logic rd;
        own = pick(req_valid, ptr_m);
        oh = '0;
        oh[own] = 1'b1;
        a = req_addr[own*24 +: 24];
        d = req_wdata[own*32 +: 32];
        s = req_size[own*3 +: 3];
        rd = req_rd_wr[own];
        exp_rd = rd ? rdata : 32'h0;

        @(negedge clk);
        gnt_log.push_back(req_gnt);
        check("issue_gnt", 32'(req_gnt), 32'(oh));
        check("issue_start", 32'(mem_start), 1);
        check("issue_busy", 32'(busy), 1);
        check("issue_rsp", 32'(rsp_valid), 0);
        check("issue_addr", 32'(mem_addr), 32'(a));
        check("issue_wdata", mem_wdata, d);
        check("issue_size", 32'(mem_size), 32'(s));
        check("issue_rd_wr", 32'(mem_rd_wr), 32'(rd));
        if (drop) req_valid[own] = 1'b0;
        mem_done = stray;

        @(negedge clk);
        mem_done = 1'b0;
        check("wait_gnt", 32'(req_gnt), 0);
        check("wait_start", 32'(mem_start), 0);
        check("wait_busy", 32'(busy), 1);
        check("wait_rsp", 32'(rsp_valid), 0);
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            check("wait_rsp", 32'(rsp_valid), 0);
            check("wait_addr", 32'(mem_addr), 32'(a));
        end
        mem_done = 1'b1;
        mem_rdata = rdata;

        @(negedge clk);
        mem_done = 1'b0;
        mem_rdata = $urandom;
        check("resp_valid", 32'(rsp_valid), 32'(oh));
        check("resp_rdata", rsp_rdata, exp_rd);
        check("resp_err", 32'(rsp_err), 0);
        check("resp_busy", 32'(busy), 1);
        check("resp_gnt", 32'(req_gnt), 0);
        check("resp_wdata", mem_wdata, d);
        check("resp_rd_wr", 32'(mem_rd_wr), 32'(rd));

        @(negedge clk);
        check("idle_rsp", 32'(rsp_valid), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_gnt", 32'(req_gnt), 0);
        ptr_m = (own + 1) % N;
        $display("txn owner=%0d rd=%0b addr=%h wdata=%h rdata=%h", own, rd, a, d, exp_rd);
    endtask

    initial begin
        logic [N-1:0] exp_order [6];
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(req_gnt), 0);
        check("rst_rsp", 32'(rsp_valid), 0);
        check("rst_start", 32'(mem_start), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", 32'(rsp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read from requester 0
        set_fields(0, 24'h000100, 32'h0, 3'd2, 1'b1);
        req_valid = 3'b001;
        run_txn(5, 32'hDEADBEEF, 1'b1, 1'b0);

        // Stray done while idle
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        check("stray_idle_busy", 32'(busy), 0);
        check("stray_idle_rsp", 32'(rsp_valid), 0);
        @(negedge clk);
        check("stray_idle_rsp2", 32'(rsp_valid), 0);
        check("stray_idle_gnt", 32'(req_gnt), 0);

        // Reset in the middle of WAIT with the pointer parked at 1
        set_fields(1, 24'h00ABCD, 32'h55AA55AA, 3'd1, 1'b1);
        req_valid = 3'b010;
        @(negedge clk);
        check("pre_rst_gnt", 32'(req_gnt), 32'(3'b010));
        req_valid = 3'b000;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_start", 32'(mem_start), 0);
        check("midrst_rsp", 32'(rsp_valid), 0);
        check("midrst_addr", 32'(mem_addr), 0);
        check("midrst_wdata", mem_wdata, 0);
        check("midrst_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        check("postrst_rsp", 32'(rsp_valid), 0);
        check("postrst_busy", 32'(busy), 0);
        set_fields(0, 24'h001000, 32'h0, 3'd2, 1'b1);
        req_valid = 3'b011;
        run_txn(2, 32'hCAFEF00D, 1'b1, 1'b0);
        run_txn(1, 32'h0BADC0DE, 1'b1, 1'b0);

        // Write from requester 2, with a stray done during ISSUE
        set_fields(2, 24'h00F00D, 32'h12345678, 3'd2, 1'b0);
        req_valid = 3'b100;
        run_txn(3, 32'hFFFFFFFF, 1'b1, 1'b1);

        // Contention: all requesters held high
        gnt_log.delete();
        for (int k = 0; k < N; k++) begin
            set_fields(k, 24'(32'h10 * (k + 1)), 32'(k + 100), 3'(k), 1'b1);
        end
        req_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
            run_txn(1 + t % 3, $urandom, 1'b0, 1'b0);
        end
        req_valid = 3'b000;
        check("order_len", 32'(gnt_log.size()), 6);
        for (int t = 0; t < 6 && t < gnt_log.size(); t++) begin
            check("order", 32'(gnt_log[t]), 32'(exp_order[t]));
        end

        // Randomized traffic
        for (int it = 0; it < 20; it++) begin
            req_valid = req_valid | 3'($urandom);
            if (req_valid == 3'b000) req_valid[$urandom_range(2, 0)] = 1'b1;
            for (int k = 0; k < N; k++) begin
                set_fields(k, 24'($urandom), $urandom, 3'($urandom), 1'($urandom));
            end
            run_txn(int'($urandom_range(6, 1)), $urandom, ($urandom_range(3, 0) != 0), 1'($urandom));
        end
        req_valid = 3'b000;
        @(negedge clk);

`ifdef PSRAM_ARB_TIMEOUT_EN
        // Timeout: controller never answers
        begin
            int own;
            logic [N-1:0] oh;
            set_fields(1, 24'h0000AA, 32'h0, 3'd2, 1'b1);
            req_valid = 3'b010;
            own = pick(req_valid, ptr_m);
            oh = '0;
            oh[own] = 1'b1;
            @(negedge clk);
            check("to_gnt", 32'(req_gnt), 32'(oh));
            req_valid = 3'b000;
            for (int w = 1; w <= 16; w++) begin
                @(negedge clk);
                check("to_wait_rsp", 32'(rsp_valid), 0);
            end
            @(negedge clk);
            check("to_rsp", 32'(rsp_valid), 32'(oh));
            check("to_err", 32'(rsp_err), 1);
            check("to_rdata", rsp_rdata, 0);
            mem_done = 1'b1;
            @(negedge clk);
            mem_done = 1'b0;
            check("to_idle_rsp", 32'(rsp_valid), 0);
            check("to_idle_busy", 32'(busy), 0);
            ptr_m = (own + 1) % N;
            $display("txn owner=%0d timeout", own);
            req_valid = 3'b001;
            run_txn(2, 32'h600DD00D, 1'b1, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
